pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline control unit for the Y86-64 PIPE processor.
- Each cycle, drives the stall and bubble controls of all five stage registers (F, D, E, M, W) from the hazard conditions.
- Holds a run-state FSM: post-reset flush, run, halt, fault.
- Optionally keeps performance counters.
- Sits beside the stage registers; replaces the per-stage stall logic.

Parameters:
- FLUSH_CYCLES, 4: cycles after reset spent bubbling the pipeline before RUN. Range 1..15.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- D_icode  input  4  icode in the D stage register.
- E_icode  input  4  icode in the E stage register.
- M_icode  input  4  icode in the M stage register.
- E_dstM  input  4  dstM in the E stage register; 4'hF = none.
- d_srcA  input  4  srcA decoded in D; 4'hF = none.
- d_srcB  input  4  srcB decoded in D; 4'hF = none.
- e_Cnd  input  1  condition result computed in E.
- m_stat  input  4  status produced in the M stage.
- W_stat  input  4  status in the W stage register. Encodings: AOK=1, HLT=2, ADR=3, INS=4.
- F_stall  output  1  hold F register.
- D_stall  output  1  hold D register.
- D_bubble  output  1  load nop into D.
- E_bubble  output  1  load nop into E.
- M_bubble  output  1  load nop into M.
- W_stall  output  1  hold W register.
- cpu_state  output  2  00 FLUSH, 01 RUN, 10 HALT, 11 FAULT.
- cycle_cnt  output  CNT_W  cycles spent in RUN.
- lu_cnt  output  CNT_W  load/use stall cycles.
- mp_cnt  output  CNT_W  mispredict cycles.

Behaviour:
- Reset (asynchronous): state=FLUSH, flush counter=0, all counters=0.
- Outputs are combinational from state and inputs. Reset-time output values are therefore the FLUSH values below.

Hazard terms (combinational):
- load_use = (E_icode==5 or E_icode==B) and E_dstM!=F and (E_dstM==d_srcA or E_dstM==d_srcB).
- ret_pend = D_icode==9 or E_icode==9 or M_icode==9.
- mispred = E_icode==7 and !e_Cnd.
- exc(s) = s is HLT, ADR or INS.

RUN outputs:
- F_stall = load_use | ret_pend.
- D_stall = load_use.
- D_bubble = mispred | (ret_pend & !load_use).
- E_bubble = mispred | load_use.
- M_bubble = exc(m_stat) | exc(W_stat).
- W_stall = exc(W_stat).
- D_stall and D_bubble are never both 1.
- load_use and mispred are mutually exclusive by icode.
- ret with load_use: F/D stall and E bubbles; D_bubble=0.

FLUSH:
- Outputs: F_stall=1, D_bubble=1, E_bubble=1, M_bubble=1, D_stall=0, W_stall=0.
- Flush counter increments each cycle.
- Enter RUN on the edge where counter==FLUSH_CYCLES-1, i.e. exactly FLUSH_CYCLES flush cycles.

RUN transitions:
- W_stat==HLT at an edge -> HALT.
- W_stat==ADR or INS at an edge -> FAULT.
- Otherwise stay in RUN. Unknown stat values (0, 5..F) are treated as FAULT.

HALT / FAULT:
- Absorbing until rst.
- Outputs: F_stall=1, D_stall=1, E_bubble=1, M_bubble=1, W_stall=1, D_bubble=0.

Reset mid-operation: immediate return to FLUSH, counters cleared; no partial state retained.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - cycle_cnt increments every RUN cycle.
  - lu_cnt increments on RUN cycles with load_use=1.
  - mp_cnt increments on RUN cycles with mispred=1.
  - All three saturate at all-ones and do not wrap; they freeze in HALT/FAULT.
- Undefined: counter registers are omitted; the three outputs are tied to 0. Ports remain for interface stability.

Test Plan:
1. rst pulse, FLUSH_CYCLES=4 -> cpu_state=00 with F_stall=D_bubble=E_bubble=M_bubble=1 for exactly 4 cycles, then 01; all counters 0.
2. RUN; E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=D_stall=E_bubble=1, D_bubble=0; lu_cnt increments by 1. Repeat with E_dstM=F -> no stall.
3. RUN; E_icode=7, e_Cnd=0 -> D_bubble=E_bubble=1, F_stall=0; mp_cnt increments. With e_Cnd=1 -> all controls 0.
4. RUN; D_icode=9 for 1 cycle, then E_icode=9, then M_icode=9 -> F_stall=1 and D_bubble=1 for 3 consecutive cycles. Also D_icode=9, E_icode=5, E_dstM=4, d_srcA=4 -> D_stall=1, D_bubble=0.
5. RUN; m_stat=3 -> M_bubble=1, W_stall=0. Next edge with W_stat=3 -> W_stall=1, then cpu_state=11 held with all freeze outputs and counters frozen. Same with W_stat=2 -> cpu_state=10.
6. Assert rst asynchronously mid-RUN, between edges -> cpu_state=00 and counters 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Control bus between the PIPE stage registers and the central pipeline controller.
// Carries the hazard inputs, the per-stage stall/bubble controls, run state and perf counters.
interface pipe_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [3:0]       D_icode;
    logic [3:0]       E_icode;
    logic [3:0]       M_icode;
    logic [3:0]       E_dstM;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic             e_Cnd;
    logic [3:0]       m_stat;
    logic [3:0]       W_stat;

    logic             F_stall;
    logic             D_stall;
    logic             D_bubble;
    logic             E_bubble;
    logic             M_bubble;
    logic             W_stall;
    logic [1:0]       cpu_state;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] lu_cnt;
    logic [CNT_W-1:0] mp_cnt;

    modport master (
        output D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB, e_Cnd, m_stat, W_stat,
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
        input  cpu_state, cycle_cnt, lu_cnt, mp_cnt
    );

    modport slave (
        input  D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB, e_Cnd, m_stat, W_stat,
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
        output cpu_state, cycle_cnt, lu_cnt, mp_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Y86-64 PIPE central control: hazard-driven stall/bubble controls plus a FLUSH/RUN/HALT/FAULT FSM.
// Define PIPE_CTRL_PERF_EN to build the saturating RUN / load-use / mispredict counters.
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 4,
    parameter int unsigned CNT_W        = 32
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);
    localparam int unsigned FC_W = 4;

    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    localparam logic [3:0] S_AOK = 4'h1;
    localparam logic [3:0] S_HLT = 4'h2;
    localparam logic [3:0] S_ADR = 4'h3;
    localparam logic [3:0] S_INS = 4'h4;

    localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_FLUSH = 2'b00,
        ST_RUN   = 2'b01,
        ST_HALT  = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [FC_W-1:0] flush_cnt;
    logic [FC_W-1:0] flush_cnt_nxt;

    logic load_use;
    logic ret_pend;
    logic mispred;
    logic m_exc;
    logic w_exc;

    function automatic logic is_exc(input logic [3:0] s);
        return (s == S_HLT) || (s == S_ADR) || (s == S_INS);
    endfunction

    // Hazard detection from the current stage-register contents
    always_comb begin
        load_use = ((bus.E_icode == I_MRMOVQ) || (bus.E_icode == I_POPQ)) &&
                   (bus.E_dstM != R_NONE) &&
                   ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
        ret_pend = (bus.D_icode == I_RET) || (bus.E_icode == I_RET) || (bus.M_icode == I_RET);
        mispred  = (bus.E_icode == I_JXX) && !bus.e_Cnd;
        m_exc    = is_exc(bus.m_stat);
        w_exc    = is_exc(bus.W_stat);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_FLUSH;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    // Next state and stage controls; HALT and FAULT freeze the whole pipe
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        bus.F_stall   = 1'b0;
        bus.D_stall   = 1'b0;
        bus.D_bubble  = 1'b0;
        bus.E_bubble  = 1'b0;
        bus.M_bubble  = 1'b0;
        bus.W_stall   = 1'b0;
        case (state)
            ST_FLUSH: begin
                bus.F_stall   = 1'b1;
                bus.D_bubble  = 1'b1;
                bus.E_bubble  = 1'b1;
                bus.M_bubble  = 1'b1;
                flush_cnt_nxt = flush_cnt + FC_W'(1);
                if (flush_cnt == FLUSH_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                bus.F_stall  = load_use | ret_pend;
                bus.D_stall  = load_use;
                bus.D_bubble = mispred | (ret_pend & !load_use);
                bus.E_bubble = mispred | load_use;
                bus.M_bubble = m_exc | w_exc;
                bus.W_stall  = w_exc;
                // Anything other than AOK/HLT, including undefined codes, is a fault
                if (bus.W_stat == S_HLT) begin
                    state_nxt = ST_HALT;
                end else if (bus.W_stat != S_AOK) begin
                    state_nxt = ST_FAULT;
                end
            end
            default: begin
                bus.F_stall  = 1'b1;
                bus.D_stall  = 1'b1;
                bus.E_bubble = 1'b1;
                bus.M_bubble = 1'b1;
                bus.W_stall  = 1'b1;
            end
        endcase
    end

    assign bus.cpu_state = state;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] lu_q;
    logic [CNT_W-1:0] mp_q;

    // Saturating counters, advanced only while running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q <= '0;
            lu_q    <= '0;
            mp_q    <= '0;
        end else if (state == ST_RUN) begin
            if (cycle_q != '1) begin
                cycle_q <= cycle_q + CNT_W'(1);
            end
            if (load_use && (lu_q != '1)) begin
                lu_q <= lu_q + CNT_W'(1);
            end
            if (mispred && (mp_q != '1)) begin
                mp_q <= mp_q + CNT_W'(1);
            end
        end
    end

    assign bus.cycle_cnt = cycle_q;
    assign bus.lu_cnt    = lu_q;
    assign bus.mp_cnt    = mp_q;
`else
    assign bus.cycle_cnt = '0;
    assign bus.lu_cnt    = '0;
    assign bus.mp_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized self-checking bench for pipe_ctrl against a cycle-level behavioural model.
// Narrow counters make saturation reachable within a single run episode.
module tb_pipe_ctrl;
    localparam int unsigned FLUSH_CYCLES = 4;
    localparam int unsigned CNT_W        = 6;
    localparam longint      CNT_MAX      = (64'd1 << CNT_W) - 1;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic rst;
    logic [3:0] d_icode, e_icode, m_icode, e_dstm, src_a, src_b, mstat, wstat;
    logic       cnd;

    pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

    assign bus.D_icode = d_icode;
    assign bus.E_icode = e_icode;
    assign bus.M_icode = m_icode;
    assign bus.E_dstM  = e_dstm;
    assign bus.d_srcA  = src_a;
    assign bus.d_srcB  = src_b;
    assign bus.e_Cnd   = cnd;
    assign bus.m_stat  = mstat;
    assign bus.W_stat  = wstat;

    pipe_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Model: 0 flush, 1 run, 2 halt, 3 fault
    int     m_mode;
    int     m_flushed;
    longint m_cyc, m_lu, m_mp;
    logic [1:0] obs_state;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_lu();
        return ((e_icode == 4'd5) || (e_icode == 4'd11)) && (e_dstm != 4'd15) &&
               ((e_dstm == src_a) || (e_dstm == src_b));
    endfunction

    function automatic bit is_mp();
        return (e_icode == 4'd7) && (cnd == 1'b0);
    endfunction

    function automatic bit is_exc_stat(input logic [3:0] s);
        return (s >= 4'd2) && (s <= 4'd4);
    endfunction

    // Expected {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
    function automatic logic [5:0] exp_ctrl();
        bit lu, rp, mp;
        lu = is_lu();
        mp = is_mp();
        rp = (d_icode == 4'd9) || (e_icode == 4'd9) || (m_icode == 4'd9);
        if (m_mode == 0) return 6'b101110;
        if (m_mode != 1) return 6'b110111;
        return {lu | rp, lu, mp | (rp & ~lu), mp | lu,
                is_exc_stat(mstat) | is_exc_stat(wstat), is_exc_stat(wstat)};
    endfunction

    function automatic longint sat_inc(input longint v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        m_mode    = 0;
        m_flushed = 0;
        m_cyc     = 0;
        m_lu      = 0;
        m_mp      = 0;
    endtask

    task automatic model_edge();
        if (rst) return;
        if (m_mode == 0) begin
            m_flushed++;
            if (m_flushed == FLUSH_CYCLES) m_mode = 1;
        end else if (m_mode == 1) begin
            if (PERF) begin
                m_cyc = sat_inc(m_cyc);
                if (is_lu()) m_lu = sat_inc(m_lu);
                if (is_mp()) m_mp = sat_inc(m_mp);
            end
            if (wstat == 4'd2) m_mode = 2;
            else if (wstat != 4'd1) m_mode = 3;
        end
    endtask

    task automatic check_outputs();
        logic [5:0] ctrl;
        ctrl = {bus.F_stall, bus.D_stall, bus.D_bubble, bus.E_bubble, bus.M_bubble, bus.W_stall};
        obs_state = bus.cpu_state;
        check("ctrl", 64'(ctrl), 64'(exp_ctrl()));
        check("cpu_state", 64'(bus.cpu_state), 64'(m_mode));
        check("cycle_cnt", 64'(bus.cycle_cnt), 64'(m_cyc));
        check("lu_cnt", 64'(bus.lu_cnt), 64'(m_lu));
        check("mp_cnt", 64'(bus.mp_cnt), 64'(m_mp));
    endtask

    // Called at a negedge with inputs applied; returns at the following negedge
    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_in(input logic [3:0] d, input logic [3:0] e, input logic [3:0] m,
                          input logic [3:0] dst, input logic [3:0] sa, input logic [3:0] sb,
                          input logic c, input logic [3:0] ms, input logic [3:0] ws);
        d_icode = d; e_icode = e; m_icode = m; e_dstm = dst;
        src_a = sa; src_b = sb; cnd = c; mstat = ms; wstat = ws;
    endtask

    task automatic quiet();
        set_in(4'd1, 4'd1, 4'd1, 4'hF, 4'hF, 4'hF, 1'b1, 4'd1, 4'd1);
    endtask

    // Reset asserted between edges; outputs must react before any clock edge
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_flush();
        int n;
        n = 0;
        quiet();
        for (int i = 0; i < 20 && m_mode == 0; i++) begin
            tick();
            if (obs_state == 2'd0) n++;
        end
        check("flush_len", 64'(n), 64'(FLUSH_CYCLES));
    endtask

    function automatic logic [3:0] pick_e_icode();
        case ($urandom_range(0, 9))
            0, 1:    return 4'd5;
            2:       return 4'd11;
            3, 4:    return 4'd7;
            5:       return 4'd9;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    task automatic rand_inputs(input int stop_pct);
        d_icode = ($urandom_range(0, 9) == 0) ? 4'd9 : 4'($urandom_range(0, 8));
        e_icode = pick_e_icode();
        m_icode = ($urandom_range(0, 9) == 0) ? 4'd9 : 4'($urandom_range(0, 8));
        e_dstm  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        src_a   = ($urandom_range(0, 2) == 0) ? e_dstm : 4'($urandom_range(0, 15));
        src_b   = ($urandom_range(0, 3) == 0) ? e_dstm : 4'($urandom_range(0, 15));
        cnd     = 1'($urandom_range(0, 1));
        mstat   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'd1;
        wstat   = (int'($urandom_range(0, 99)) < stop_pct) ? 4'($urandom_range(0, 15)) : 4'd1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        quiet();
        model_reset();
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
        run_flush();

        // Load/use and its suppression when dstM is none
        set_in(4'd1, 4'd5, 4'd1, 4'd3, 4'd3, 4'hF, 1'b1, 4'd1, 4'd1); tick();
        set_in(4'd1, 4'd5, 4'd1, 4'hF, 4'hF, 4'd2, 1'b1, 4'd1, 4'd1); tick();
        // Mispredicted and correctly predicted jump
        set_in(4'd1, 4'd7, 4'd1, 4'hF, 4'd2, 4'd2, 1'b0, 4'd1, 4'd1); tick();
        set_in(4'd1, 4'd7, 4'd1, 4'hF, 4'd2, 4'd2, 1'b1, 4'd1, 4'd1); tick();
        // ret walking through D, E, M; then ret combined with load/use
        set_in(4'd9, 4'd1, 4'd1, 4'hF, 4'hF, 4'hF, 1'b1, 4'd1, 4'd1); tick();
        set_in(4'd1, 4'd9, 4'd1, 4'hF, 4'hF, 4'hF, 1'b1, 4'd1, 4'd1); tick();
        set_in(4'd1, 4'd1, 4'd9, 4'hF, 4'hF, 4'hF, 1'b1, 4'd1, 4'd1); tick();
        set_in(4'd9, 4'd5, 4'd1, 4'd4, 4'd4, 4'hF, 1'b1, 4'd1, 4'd1); tick();
        // Exception in M, then in W -> FAULT and frozen
        set_in(4'd1, 4'd1, 4'd1, 4'hF, 4'hF, 4'hF, 1'b1, 4'd3, 4'd1); tick();
        set_in(4'd1, 4'd5, 4'd1, 4'd3, 4'd3, 4'hF, 1'b0, 4'd1, 4'd3); tick();
        for (int i = 0; i < 4; i++) begin rand_inputs(30); tick(); end
        check("fault_hold", 64'(obs_state), 64'd3);

        do_reset();
        run_flush();
        for (int i = 0; i < 3; i++) begin rand_inputs(0); tick(); end
        set_in(4'd1, 4'd1, 4'd1, 4'hF, 4'hF, 4'hF, 1'b1, 4'd1, 4'd2); tick();
        for (int i = 0; i < 4; i++) begin rand_inputs(30); tick(); end
        check("halt_hold", 64'(obs_state), 64'd2);

        // Random episodes; one takes an asynchronous reset mid-run
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            run_flush();
            for (int i = 0; i < 150 && m_mode == 1; i++) begin
                rand_inputs((ep < 2) ? 0 : 1);
                tick();
                if (ep == 2 && i == 40) begin
                    do_reset();
                    run_flush();
                end
            end
            if (m_mode == 1) begin
                rand_inputs(0);
                wstat = (ep % 2 == 0) ? 4'd2 : 4'($urandom_range(3, 15));
                tick();
            end
            for (int i = 0; i < 5; i++) begin rand_inputs(20); tick(); end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
